// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard control: load-use stalls, jump/branch redirects with multi-cycle flush,
// and instruction-memory wait holds. Optional perf counters under HAZARD_PERF_CNT_EN.
module fetch_hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned WAIT_MAX    = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        ExtWait,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [31:0] JumpAddress,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WCNT_W = 8;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_FLUSH    = 2'd2,
        S_WAIT     = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        A_NORM = 3'd0,
        A_BR   = 3'd1,
        A_JMP  = 3'd2,
        A_LU   = 3'd3,
        A_WT   = 3'd4,
        A_HOLD = 3'd5,
        A_FL   = 3'd6
    } act_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    act_t                act;
    logic                lu_hazard;
    logic                wait_release;

    assign lu_hazard = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                       ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
    assign wait_release = !ExtWait || (wcnt_q >= WCNT_W'(WAIT_MAX));

    // Per-cycle decision, shared by next-state and output logic (priority: branch > jump > LU > wait)
    always_comb begin
        act = A_NORM;
        unique case (state_q)
            S_RUN: begin
                if (BranchTaken)    act = A_BR;
                else if (Jump)      act = A_JMP;
                else if (lu_hazard) act = A_LU;
                else if (ExtWait)   act = A_WT;
                else                act = A_NORM;
            end
            S_LU_STALL: begin
                if (BranchTaken)  act = A_BR;
                else if (Jump)    act = A_JMP;
                else if (ExtWait) act = A_WT;
                else              act = A_NORM;
            end
            S_FLUSH: begin
                if (BranchTaken) act = A_BR;
                else             act = A_FL;
            end
            S_WAIT: begin
                // Releasing cycle acts as RUN with ExtWait masked so a forced release really drops the stall
                if (BranchTaken)       act = A_BR;
                else if (!wait_release) act = A_HOLD;
                else if (Jump)         act = A_JMP;
                else if (lu_hazard)    act = A_LU;
                else                   act = A_NORM;
            end
            default: act = A_NORM;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_RUN;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        unique case (act)
            A_BR: begin
                if (FLUSH_DEPTH > 1) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
                end
            end
            A_LU: state_d = S_LU_STALL;
            A_WT: begin
                state_d = S_WAIT;
                wcnt_d  = WCNT_W'(1);
            end
            A_HOLD: begin
                state_d = S_WAIT;
                wcnt_d  = (wcnt_q == {WCNT_W{1'b1}}) ? wcnt_q : wcnt_q + WCNT_W'(1);
            end
            A_FL: begin
                if (cnt_q > CNT_W'(1)) begin
                    state_d = S_FLUSH;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        JumpAddress = 32'd0;
        IFID_Write  = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Busy        = 1'b0;
        if (Rst) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else begin
            Busy = (state_q != S_RUN);
            unique case (act)
                A_NORM: begin
                    PCWrite    = 1'b1;
                    IFID_Write = 1'b1;
                end
                A_BR: begin
                    PCWrite     = 1'b1;
                    PCSrc       = 1'b1;
                    JumpAddress = BranchTarget;
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end
                A_JMP: begin
                    PCWrite     = 1'b1;
                    PCSrc       = 1'b1;
                    JumpAddress = JumpTarget;
                    IFID_Flush  = 1'b1;
                end
                A_FL: begin
                    PCWrite     = 1'b1;
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end
                default: IDEX_Bubble = 1'b1;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Stall / flush cycle counters, wrapping
    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (!PCWrite)   StallCount <= StallCount + 32'd1;
            if (IFID_Flush) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl (defaults FLUSH_DEPTH=2, WAIT_MAX=15): vector table
// through a scoreboard queue plus a long ExtWait sequence; perf counters checked when enabled.
module tb_fetch_hazard_ctrl;

    typedef struct {
        logic        rst, memrd;
        logic [4:0]  irt, rs, rt;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        ew;
        logic        pcw, src;
        logic [31:0] ja;
        logic        ifw, ifw_dc, fl, bub, busy;
    } vec_t;

    logic        Clk, Rst, IDEX_MemRead, Jump, BranchTaken, ExtWait;
    logic [4:0]  IDEX_Rt, IFID_Rs, IFID_Rt;
    logic [31:0] JumpTarget, BranchTarget, JumpAddress;
    logic        PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Bubble, Busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCount, FlushCount;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t sbq[$];
    vec_t tbl[$];

    localparam logic [31:0] JT = 32'h0040_0040;

    fetch_hazard_ctrl dut (
        .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .Jump(Jump), .JumpTarget(JumpTarget),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .ExtWait(ExtWait),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .JumpAddress(JumpAddress), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble), .Busy(Busy)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t iv(input logic rst, input logic memrd, input logic [4:0] irt,
                                input logic [4:0] rs, input logic [4:0] rt, input logic jump,
                                input logic [31:0] jt, input logic br, input logic [31:0] bt,
                                input logic ew);
        vec_t v;
        v.rst = rst; v.memrd = memrd; v.irt = irt; v.rs = rs; v.rt = rt;
        v.jump = jump; v.jt = jt; v.br = br; v.bt = bt; v.ew = ew;
        v.pcw = 1'b0; v.src = 1'b0; v.ja = 32'd0; v.ifw = 1'b0; v.ifw_dc = 1'b0;
        v.fl = 1'b0; v.bub = 1'b0; v.busy = 1'b0;
        return v;
    endfunction

    function automatic vec_t q_in(input logic rst, input logic ew);
        return iv(rst, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, ew);
    endfunction

    function automatic vec_t e_rst(input vec_t v);
        vec_t r = v;
        r.fl = 1'b1; r.bub = 1'b1;
        return r;
    endfunction

    function automatic vec_t e_norm(input vec_t v, input logic busy);
        vec_t r = v;
        r.pcw = 1'b1; r.ifw = 1'b1; r.busy = busy;
        return r;
    endfunction

    function automatic vec_t e_stall(input vec_t v, input logic busy);
        vec_t r = v;
        r.bub = 1'b1; r.busy = busy;
        return r;
    endfunction

    function automatic vec_t e_redir(input vec_t v, input logic [31:0] ja, input logic bub,
                                     input logic busy);
        vec_t r = v;
        r.pcw = 1'b1; r.src = 1'b1; r.ja = ja; r.fl = 1'b1; r.bub = bub;
        r.ifw_dc = 1'b1; r.busy = busy;
        return r;
    endfunction

    function automatic vec_t e_flush(input vec_t v);
        vec_t r = v;
        r.pcw = 1'b1; r.fl = 1'b1; r.bub = 1'b1; r.ifw_dc = 1'b1; r.busy = 1'b1;
        return r;
    endfunction

    task automatic check_front(input string tag, input int idx);
        vec_t e;
        logic [37:0] got, exp, mask;
        e    = sbq.pop_front();
        got  = {PCWrite, PCSrc, JumpAddress, IFID_Write, IFID_Flush, IDEX_Bubble, Busy};
        exp  = {e.pcw, e.src, e.ja, e.ifw, e.fl, e.bub, e.busy};
        mask = e.ifw_dc ? ~(38'd1 << 3) : ~38'd0;
        checks++;
        if ((got & mask) != (exp & mask)) begin
            errors++;
            $display("FAIL %s[%0d]: got pcw=%b src=%b ja=%h ifw=%b fl=%b bub=%b busy=%b, expected pcw=%b src=%b ja=%h ifw=%b(dc=%b) fl=%b bub=%b busy=%b",
                     tag, idx, PCWrite, PCSrc, JumpAddress, IFID_Write, IFID_Flush, IDEX_Bubble, Busy,
                     e.pcw, e.src, e.ja, e.ifw, e.ifw_dc, e.fl, e.bub, e.busy);
        end
    endtask

    // Drive one cycle of inputs, check the combinational response mid-cycle, advance past the edge
    task automatic step(input vec_t v, input string tag, input int idx);
        Rst = v.rst; IDEX_MemRead = v.memrd; IDEX_Rt = v.irt; IFID_Rs = v.rs; IFID_Rt = v.rt;
        Jump = v.jump; JumpTarget = v.jt; BranchTaken = v.br; BranchTarget = v.bt; ExtWait = v.ew;
        sbq.push_back(v);
        #4;
        check_front(tag, idx);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vec_t lu8, lu9;
        vec_t v;
        Rst = 1'b1; IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        Jump = 1'b0; JumpTarget = 32'd0; BranchTaken = 1'b0; BranchTarget = 32'd0; ExtWait = 1'b0;

        lu8 = iv(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        lu9 = iv(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        tbl.push_back(e_rst(q_in(1'b1, 1'b0)));
        tbl.push_back(e_rst(q_in(1'b1, 1'b0)));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_stall(lu8, 1'b0));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b1));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_norm(iv(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0), 1'b0));
        tbl.push_back(e_stall(lu9, 1'b0));
        tbl.push_back(e_norm(lu9, 1'b1));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_redir(iv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, JT, 1'b0, 32'd0, 1'b0), JT, 1'b0, 1'b0));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_redir(iv(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, JT, 1'b1, 32'h100, 1'b0), 32'h100, 1'b1, 1'b0));
        tbl.push_back(e_flush(q_in(1'b0, 1'b0)));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_redir(iv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h200, 1'b0), 32'h200, 1'b1, 1'b0));
        tbl.push_back(e_redir(iv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0), 32'h300, 1'b1, 1'b1));
        tbl.push_back(e_flush(iv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, JT, 1'b0, 32'd0, 1'b0)));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b0));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b1));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b1));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b1));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b0));
        tbl.push_back(e_redir(iv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b1), 32'h400, 1'b1, 1'b1));
        tbl.push_back(e_flush(q_in(1'b0, 1'b0)));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b0));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b1));
        tbl.push_back(e_rst(q_in(1'b1, 1'b1)));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_stall(lu8, 1'b0));
        tbl.push_back(e_rst(q_in(1'b1, 1'b0)));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        tbl.push_back(e_stall(lu8, 1'b0));
        tbl.push_back(e_stall(q_in(1'b0, 1'b1), 1'b1));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b1));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));
        v = lu8; v.jump = 1'b1; v.jt = JT;
        tbl.push_back(e_redir(v, JT, 1'b0, 1'b0));
        tbl.push_back(e_norm(q_in(1'b0, 1'b0), 1'b0));

        @(posedge Clk);
        #1;
        foreach (tbl[i]) step(tbl[i], "vec", i);

        // ExtWait held 20 cycles: 15 stall cycles, forced release, then a fresh wait begins
        for (int i = 0; i < 20; i++) begin
            if (i < 15)       v = e_stall(q_in(1'b0, 1'b1), (i > 0));
            else if (i == 15) v = e_norm(q_in(1'b0, 1'b1), 1'b1);
            else if (i == 16) v = e_stall(q_in(1'b0, 1'b1), 1'b0);
            else              v = e_stall(q_in(1'b0, 1'b1), 1'b1);
            step(v, "waitmax", i);
        end
        step(e_norm(q_in(1'b0, 1'b0), 1'b1), "waitmax", 20);
        step(e_norm(q_in(1'b0, 1'b0), 1'b0), "waitmax", 21);

        // One load-use stall plus one branch straight after reset
        step(e_rst(q_in(1'b1, 1'b0)), "perf", 0);
        step(e_stall(lu8, 1'b0), "perf", 1);
        step(e_norm(q_in(1'b0, 1'b0), 1'b1), "perf", 2);
        step(e_redir(iv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h500, 1'b0), 32'h500, 1'b1, 1'b0), "perf", 3);
        step(e_flush(q_in(1'b0, 1'b0)), "perf", 4);
        step(e_norm(q_in(1'b0, 1'b0), 1'b0), "perf", 5);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (StallCount != 32'd1) begin
            errors++;
            $display("FAIL stall_count: got %0d, expected 1", StallCount);
        end
        checks++;
        if (FlushCount != 32'd2) begin
            errors++;
            $display("FAIL flush_count: got %0d, expected 2", FlushCount);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Control unit for the instruction-fetch stage of the pipelined MIPS datapath.
- Drives the PC write-enable, next-PC select and redirect target into the fetch stage.
- Drives the IF/ID write/flush controls and the ID/EX bubble insert.
- Sequences load-use stalls, jump/branch redirects with multi-cycle flush, and external memory-wait holds.

Parameters:
- FLUSH_DEPTH, 2, cycles IFID_Flush stays asserted after a taken-branch redirect (range 1..7).
- WAIT_MAX, 15, cap on consecutive ExtWait cycles before forced release (range 1..255).

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous active-high reset
- IDEX_MemRead  in  1  instruction in ID/EX is a load
- IDEX_Rt  in  5  load destination register in ID/EX
- IFID_Rs  in  5  source register of instruction in IF/ID
- IFID_Rt  in  5  second source register of instruction in IF/ID
- Jump  in  1  jump decoded in ID
- JumpTarget  in  32  jump target from ID
- BranchTaken  in  1  branch resolved taken in EX/MEM
- BranchTarget  in  32  branch target from EX/MEM
- ExtWait  in  1  instruction memory not ready
- PCWrite  out  1  PC load enable
- PCSrc  out  1  1 = select JumpAddress, 0 = PC+4
- JumpAddress  out  32  redirect target
- IFID_Write  out  1  IF/ID register load enable
- IFID_Flush  out  1  zero the IF/ID register
- IDEX_Bubble  out  1  force ID/EX control signals to zero
- Busy  out  1  state != RUN

Behaviour:
- Decided interface: one clock Clk; reset Rst is synchronous and active-high.
- Reset: state=RUN, counters=0.
  - Outputs during the reset cycle: PCWrite=0, PCSrc=0, JumpAddress=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, Busy=0.
  - A reset mid-stall, mid-flush or mid-wait abandons the operation: RUN on the next edge, no pending redirect retained.
- Outputs are combinational from state and current inputs. All decisions take effect in the same cycle; state updates on the edge.
- Load-use hazard (LU): IDEX_MemRead=1, IDEX_Rt!=0, and IDEX_Rt equals IFID_Rs or IFID_Rt.
- Priority per cycle: BranchTaken > Jump > LU > ExtWait > normal.
- State RUN:
  - BranchTaken: PCWrite=1, PCSrc=1, JumpAddress=BranchTarget, IFID_Flush=1, IDEX_Bubble=1. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1; else stay in RUN.
  - Jump (no branch): PCWrite=1, PCSrc=1, JumpAddress=JumpTarget, IFID_Flush=1, IDEX_Bubble=0. Stay in RUN.
  - LU: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Go to LU_STALL.
  - ExtWait: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Go to WAIT with wcnt=1.
  - Otherwise: PCWrite=1, IFID_Write=1, all other outputs 0.
- State LU_STALL (exactly one cycle):
  - Behaves as RUN, except LU is ignored (the stalled load has moved on).
  - Returns to RUN unless a branch or ExtWait sends it elsewhere.
- State FLUSH:
  - IFID_Flush=1, IDEX_Bubble=1, PCWrite=1 (fetch continues down the target path), PCSrc=0; Jump and LU are ignored.
  - cnt decrements each cycle; on reaching 1, return to RUN next edge.
  - A new BranchTaken in FLUSH redirects immediately (PCSrc=1, JumpAddress=BranchTarget) and reloads cnt=FLUSH_DEPTH-1.
- State WAIT:
  - PCWrite=0, IFID_Write=0, IDEX_Bubble=1; wcnt increments (8-bit, saturating).
  - ExtWait=0 or wcnt==WAIT_MAX: return to RUN. On the WAIT_MAX exit the stall drops regardless of ExtWait.
  - BranchTaken in WAIT: redirect taken (PCWrite=1 overrides the hold); go to FLUSH.
- JumpAddress is 0 whenever PCSrc=0.
- No output ever asserts PCSrc=1 with PCWrite=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds output ports StallCount[31:0] and FlushCount[31:0].
  - StallCount increments every cycle with PCWrite=0 and Rst=0.
  - FlushCount increments every cycle with IFID_Flush=1 and Rst=0.
  - Both wrap at 2^32 and clear on Rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Rst=1 for 2 cycles, then release with quiet inputs -> PCWrite=0 and IFID_Flush=1 during reset. First cycle after release: PCWrite=1, IFID_Write=1, PCSrc=0, Busy=0.
- IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for 1 cycle -> that cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Next cycle LU_STALL with inputs cleared: PCWrite=1, Busy=1. Following cycle RUN. Repeat with IDEX_Rt=0 -> no stall.
- Jump=1, JumpTarget=0x00400040 -> same cycle PCSrc=1, JumpAddress=0x00400040, IFID_Flush=1, IDEX_Bubble=0. Next cycle normal.
- BranchTaken=1, BranchTarget=0x00000100 together with Jump=1 and LU, FLUSH_DEPTH=2 -> branch wins: JumpAddress=0x00000100, PCSrc=1. Next cycle IFID_Flush=1, PCSrc=0. Third cycle RUN.
- ExtWait held high 20 cycles, WAIT_MAX=15 -> PCWrite=0 for 15 cycles, then forced release to RUN. ExtWait dropped after 3 cycles -> release after 3 cycles. Rst asserted mid-WAIT -> RUN next edge.
- With HAZARD_PERF_CNT_EN: one LU stall + one branch (FLUSH_DEPTH=2) -> StallCount=1, FlushCount=2.
